// File: rtl/nlms_engine.sv
// Single-channel normalised-LMS adaptive FIR engine sharing one datapath for update, clear and MAC.
// Optional leaky update is enabled by defining LEAKAGE_EN.
module nlms_engine #(
  parameter int TAPS       = 64,
  parameter int DATA_W     = 16,
  parameter int COEFF_W    = 16,
  parameter int COEFF_FRAC = 12,
  parameter int MU_SHIFT   = 4,
  parameter int LEAK_SHIFT = 10
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   ready_in,
  input  logic signed [DATA_W-1:0]               x_in,
  input  logic signed [DATA_W-1:0]               error_in,
  input  logic [1:0]                             mode_in,
  output logic signed [DATA_W-1:0]               y_out,
  output logic                                   done_out,
  output logic                                   busy_out,
  output logic [2*DATA_W+$clog2(TAPS)-1:0]       norm_out,
  output logic                                   overrun_out
);

  localparam int PTR_W   = $clog2(TAPS);
  localparam int NORM_W  = 2*DATA_W + PTR_W;
  localparam int NS_W    = $clog2(NORM_W);
  localparam int SH_W    = 8;
  localparam int PROD_W  = 2*DATA_W;
  localparam int DELTA_W = PROD_W + COEFF_FRAC;
  localparam int SUM_W   = DELTA_W + 2;
  localparam int MAC_W   = DATA_W + COEFF_W;
  localparam int ACC_W   = DATA_W + COEFF_W + PTR_W;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_ADAPT  = 2'b10;
  localparam logic [1:0] MODE_CLEAR  = 2'b11;

  localparam logic signed [COEFF_W-1:0] COEFF_MAX = {1'b0, {(COEFF_W-1){1'b1}}};
  localparam logic signed [COEFF_W-1:0] COEFF_MIN = {1'b1, {(COEFF_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0]   W_MAX     = SUM_W'(COEFF_MAX);
  localparam logic signed [SUM_W-1:0]   W_MIN     = SUM_W'(COEFF_MIN);
  localparam logic signed [DATA_W-1:0]  DATA_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0]  DATA_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]   Y_MAX     = ACC_W'(DATA_MAX);
  localparam logic signed [ACC_W-1:0]   Y_MIN     = ACC_W'(DATA_MIN);

  if (TAPS < 4 || TAPS > 256 || (TAPS & (TAPS - 1)) != 0 || LEAK_SHIFT < 1) begin : g_bad_cfg
    $error("nlms_engine: unsupported TAPS or LEAK_SHIFT");
  end

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_CLEAR, S_UPDATE, S_FILTER, S_DONE} state_t;

  state_t                     state_reg, state_next;
  logic [1:0]                 mode_reg;
  logic signed [DATA_W-1:0]   err_reg, x_reg, y_reg;
  logic [PTR_W-1:0]           wr_ptr_reg, k_reg;
  logic [NS_W-1:0]            nshift_reg;
  logic [NORM_W-1:0]          norm_reg;
  logic signed [ACC_W-1:0]    acc_reg;
  logic                       overrun_reg;
  logic signed [DATA_W-1:0]   buf_mem  [TAPS];
  logic signed [COEFF_W-1:0]  coef_mem [TAPS];

  logic                       last_tap;
  logic [PTR_W-1:0]           rd_idx;
  logic signed [DATA_W-1:0]   x_k, x_old;
  logic signed [COEFF_W-1:0]  w_k, w_sat;
  logic signed [PROD_W-1:0]   sq_new, sq_old, prod_ex;
  logic [NORM_W-1:0]          norm_new, norm_ored;
  logic [NS_W-1:0]            nshift_new;
  logic [SH_W-1:0]            shamt;
  logic signed [DELTA_W-1:0]  delta_full, delta;
  logic signed [SUM_W-1:0]    w_sum;
  logic signed [MAC_W-1:0]    mac;
  logic signed [ACC_W-1:0]    acc_sum, y_shift;
  logic signed [DATA_W-1:0]   y_sat;

  always_comb begin
    state_next = state_reg;
    last_tap   = (k_reg == PTR_W'(TAPS - 1));
    case (state_reg)
      S_IDLE:    if (ready_in) state_next = S_CAPTURE;
      S_CAPTURE: begin
        if (mode_reg == MODE_ADAPT)      state_next = S_UPDATE;
        else if (mode_reg == MODE_CLEAR) state_next = S_CLEAR;
        else                             state_next = S_FILTER;
      end
      S_UPDATE,
      S_CLEAR:   if (last_tap) state_next = S_FILTER;
      S_FILTER:  if (last_tap) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // k counts taps; x[n-k] sits k entries behind the slot just written
  always_comb begin
    rd_idx   = wr_ptr_reg - PTR_W'(1) - k_reg;
    x_k      = buf_mem[rd_idx];
    w_k      = coef_mem[k_reg];
    x_old    = buf_mem[wr_ptr_reg];
    sq_new   = x_reg * x_reg;
    sq_old   = x_old * x_old;
    norm_new = norm_reg + NORM_W'($unsigned(sq_new)) - NORM_W'($unsigned(sq_old));
    norm_ored  = norm_new | NORM_W'(1);
    nshift_new = '0;
    for (int i = 0; i < NORM_W; i++) begin
      if (norm_ored[i]) nshift_new = NS_W'(i);
    end

    prod_ex    = err_reg * x_k;
    delta_full = DELTA_W'(prod_ex) <<< COEFF_FRAC;
    shamt      = SH_W'(MU_SHIFT) + SH_W'(nshift_reg);
    delta      = delta_full >>> shamt;
`ifdef LEAKAGE_EN
    w_sum = SUM_W'(w_k) - SUM_W'(w_k >>> LEAK_SHIFT) + SUM_W'(delta);
`else
    w_sum = SUM_W'(w_k) + SUM_W'(delta);
`endif
    w_sat = w_sum[COEFF_W-1:0];
    if (w_sum > W_MAX)      w_sat = COEFF_MAX;
    else if (w_sum < W_MIN) w_sat = COEFF_MIN;

    mac     = w_k * x_k;
    acc_sum = acc_reg + ACC_W'(mac);
    y_shift = acc_sum >>> COEFF_FRAC;
    y_sat   = y_shift[DATA_W-1:0];
    if (y_shift > Y_MAX)      y_sat = DATA_MAX;
    else if (y_shift < Y_MIN) y_sat = DATA_MIN;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg   <= S_IDLE;
      mode_reg    <= '0;
      err_reg     <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      wr_ptr_reg  <= '0;
      k_reg       <= '0;
      nshift_reg  <= '0;
      norm_reg    <= '0;
      acc_reg     <= '0;
      overrun_reg <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        buf_mem[i]  <= '0;
        coef_mem[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      if (ready_in && state_reg != S_IDLE) overrun_reg <= 1'b1;
      case (state_reg)
        S_IDLE: begin
          if (ready_in) begin
            x_reg    <= x_in;
            err_reg  <= error_in;
            mode_reg <= mode_in;
          end
        end
        S_CAPTURE: begin
          buf_mem[wr_ptr_reg] <= x_reg;
          norm_reg            <= norm_new;
          nshift_reg          <= nshift_new;
          wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
          k_reg               <= '0;
          acc_reg             <= '0;
        end
        S_UPDATE: begin
          coef_mem[k_reg] <= w_sat;
          k_reg           <= k_reg + PTR_W'(1);
        end
        S_CLEAR: begin
          coef_mem[k_reg] <= '0;
          k_reg           <= k_reg + PTR_W'(1);
        end
        S_FILTER: begin
          acc_reg <= acc_sum;
          k_reg   <= k_reg + PTR_W'(1);
          // y is loaded on the edge into DONE so it is valid alongside done_out
          if (last_tap) y_reg <= (mode_reg == MODE_BYPASS) ? '0 : y_sat;
        end
        default: ;
      endcase
    end
  end

  assign y_out       = y_reg;
  assign done_out    = (state_reg == S_DONE);
  assign busy_out    = (state_reg != S_IDLE);
  assign norm_out    = norm_reg;
  assign overrun_out = overrun_reg;

endmodule

// File: tb/tb_nlms_engine.sv
// Scoreboard bench for nlms_engine: a behavioural NLMS model predicts y, norm and latency per frame.
module tb_nlms_engine;
  localparam int TAPS       = 4;
  localparam int DATA_W     = 16;
  localparam int COEFF_W    = 12;
  localparam int COEFF_FRAC = 8;
  localparam int MU_SHIFT   = 2;
  localparam int LEAK_SHIFT = 10;
  localparam int NORM_W     = 2*DATA_W + $clog2(TAPS);
  localparam int M_BYP = 0, M_FRZ = 1, M_ADP = 2, M_CLR = 3;

  logic                     clk_in = 1'b0;
  logic                     rst_in = 1'b0;
  logic                     ready_in = 1'b0;
  logic signed [DATA_W-1:0] x_in = '0;
  logic signed [DATA_W-1:0] error_in = '0;
  logic [1:0]               mode_in = '0;
  logic signed [DATA_W-1:0] y_out;
  logic                     done_out;
  logic                     busy_out;
  logic [NORM_W-1:0]        norm_out;
  logic                     overrun_out;

  nlms_engine #(
    .TAPS(TAPS), .DATA_W(DATA_W), .COEFF_W(COEFF_W), .COEFF_FRAC(COEFF_FRAC),
    .MU_SHIFT(MU_SHIFT), .LEAK_SHIFT(LEAK_SHIFT)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .ready_in(ready_in), .x_in(x_in),
    .error_in(error_in), .mode_in(mode_in), .y_out(y_out), .done_out(done_out),
    .busy_out(busy_out), .norm_out(norm_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    longint y;
    longint norm;
    int     lat;
    longint t0;
    int     mode;
  } exp_t;

  exp_t   sb_q[$];
  longint cyc = 0;
  int     done_count = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // behavioural reference model
  longint m_buf[TAPS];
  longint m_w[TAPS];
  int     m_ptr;
  longint m_norm;

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      m_buf[i] = 0;
      m_w[i]   = 0;
    end
    m_ptr  = 0;
    m_norm = 0;
  endtask

  task automatic model_frame(input longint x, input longint e, input int mode, output longint y);
    longint old, acc, xk, d, nw, wmax, wmin;
    int ns;
    wmax = (longint'(1) <<< (COEFF_W-1)) - 1;
    wmin = -(longint'(1) <<< (COEFF_W-1));
    old = m_buf[m_ptr];
    m_norm = m_norm + x*x - old*old;
    m_buf[m_ptr] = x;
    m_ptr = (m_ptr + 1) % TAPS;
    ns = 0;
    for (int i = 0; i < NORM_W; i++)
      if ((((m_norm | 1) >> i) & 1) == 1) ns = i;
    if (mode == M_ADP) begin
      for (int k = 0; k < TAPS; k++) begin
        xk = m_buf[(m_ptr - 1 - k + 2*TAPS) % TAPS];
        d  = (e * xk * (longint'(1) <<< COEFF_FRAC)) >>> (MU_SHIFT + ns);
`ifdef LEAKAGE_EN
        nw = m_w[k] - (m_w[k] >>> LEAK_SHIFT) + d;
`else
        nw = m_w[k] + d;
`endif
        if (nw > wmax) nw = wmax;
        if (nw < wmin) nw = wmin;
        m_w[k] = nw;
      end
    end else if (mode == M_CLR) begin
      for (int k = 0; k < TAPS; k++) m_w[k] = 0;
    end
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += m_w[k] * m_buf[(m_ptr - 1 - k + 2*TAPS) % TAPS];
    y = acc >>> COEFF_FRAC;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    if (mode == M_BYP) y = 0;
  endtask

  task automatic push_expected(input longint x, input longint e, input int mode);
    exp_t it;
    longint y;
    model_frame(x, e, mode, y);
    it.y    = y;
    it.norm = m_norm;
    it.lat  = (mode >= M_ADP) ? 2*TAPS + 2 : TAPS + 2;
    it.t0   = cyc;
    it.mode = mode;
    sb_q.push_back(it);
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in && done_out) begin
      done_count++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("y_out", $signed(y_out), e.y);
        check("norm_out", {30'd0, norm_out}, e.norm);
        check("latency", cyc - e.t0, e.lat);
        $display("[TB] frame mode=%0d y=%0d norm=%0d latency=%0d", e.mode, y_out, norm_out, cyc - e.t0);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk_in);
    if (sb_q.size() != 0) begin
      check("frame_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    @(negedge clk_in);
  endtask

  // drives one frame; mode_in is changed right after the strobe to prove it is latched
  task automatic send_frame(input longint x, input longint e, input int mode);
    push_expected(x, e, mode);
    x_in     = DATA_W'(x);
    error_in = DATA_W'(e);
    mode_in  = 2'(mode);
    ready_in = 1'b1;
    @(negedge clk_in);
    ready_in = 1'b0;
    x_in     = '0;
    error_in = '0;
    mode_in  = 2'(mode ^ 1);
    wait_idle();
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    model_reset();
    @(negedge clk_in);
  endtask

  initial begin
    int saved_done;
    model_reset();
    do_reset();
    check("rst_y", $signed(y_out), 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_norm", {30'd0, norm_out}, 0);
    check("rst_overrun", overrun_out, 0);

    send_frame(1000, 0, M_FRZ);

    do_reset();
    send_frame(256, 1024, M_ADP);
    check("adapt_y_const", $signed(y_out), 256);
    send_frame(512, 0, M_BYP);
    check("bypass_norm_const", {30'd0, norm_out}, 327680);
    send_frame(100, 0, M_FRZ);

    do_reset();
    for (int v = 100; v <= 500; v += 100) send_frame(v, 0, M_FRZ);
    check("wrap_norm_const", {30'd0, norm_out}, 540000);

    do_reset();
    for (int i = 0; i < 80; i++) send_frame(32767, 32767, M_ADP);
    for (int i = 0; i < 3; i++) send_frame(0, 0, M_FRZ);
    send_frame(100, 0, M_FRZ);
    check("w0_pinned_const", $signed(y_out), 799);
    send_frame(0, 0, M_CLR);
    send_frame(100, 0, M_FRZ);
    check("cleared_const", $signed(y_out), 0);

    check("overrun_before", overrun_out, 0);
    push_expected(1000, 500, M_ADP);
    x_in = 16'sd1000; error_in = 16'sd500; mode_in = 2'(M_ADP); ready_in = 1'b1;
    @(negedge clk_in);
    ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    x_in = 16'sd30000; ready_in = 1'b1;
    @(negedge clk_in);
    ready_in = 1'b0;
    wait_idle();
    check("overrun_set", overrun_out, 1);
    send_frame(200, 100, M_FRZ);
    check("overrun_sticky", overrun_out, 1);

    saved_done = done_count;
    x_in = 16'sd1234; mode_in = 2'(M_FRZ); ready_in = 1'b1;
    @(negedge clk_in);
    ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("abort_busy", busy_out, 0);
    check("abort_y", $signed(y_out), 0);
    check("abort_norm", {30'd0, norm_out}, 0);
    check("abort_overrun", overrun_out, 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    model_reset();
    repeat (12) @(negedge clk_in);
    check("abort_no_done", done_count, saved_done);
    check("abort_busy_after", busy_out, 0);
    check("abort_y_after", $signed(y_out), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
